// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package divider_pkg;

  // Divider control states.
  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  // Width of a step counter that must be able to hold the value size.
  function automatic int unsigned cnt_width(input int unsigned size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract
// the divisor and keep the difference when it does not go negative.
module divider_step #(
  parameter int unsigned SIZE = 4
) (
  input  logic [SIZE-1:0] rem,
  input  logic            bit_in,
  input  logic [SIZE-1:0] divisor,
  output logic [SIZE-1:0] rem_next,
  output logic            q_bit
);

  logic [SIZE:0] rem_shift;
  logic [SIZE:0] diff;

  // Trial subtract at SIZE+1 bits; a set top bit of the difference is the borrow,
  // i.e. rem_shift < divisor, because the partial remainder is always below divisor.
  always_comb begin
    rem_shift = {rem, bit_in};
    diff      = rem_shift - {1'b0, divisor};
    q_bit     = ~diff[SIZE];
    rem_next  = q_bit ? diff[SIZE-1:0] : rem_shift[SIZE-1:0];
  end

endmodule

// File: rtl/divider_seq.sv
// Multi-cycle restoring divider: one quotient bit per clock with a start/busy/done
// handshake. Define DIVIDER_SIGNED_EN for two's complement operands (magnitudes go
// through the unsigned core, signs are fixed up on the result edge).
module divider_seq
  import divider_pkg::*;
#(
  parameter int unsigned SIZE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] q,
  output logic [SIZE-1:0] r,
  output logic            div_zero,
  output logic            over
);

  localparam int unsigned CntW = cnt_width(SIZE);
  localparam logic [CntW-1:0] LastCnt = CntW'(SIZE - 1);

  state_e state_q, state_d;

  logic [SIZE-1:0] rem_q, rem_d;
  logic [SIZE-1:0] shreg_q, shreg_d;
  logic [SIZE-1:0] divisor_q, divisor_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0] q_q, q_d;
  logic [SIZE-1:0] r_q, r_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            div_zero_q, div_zero_d;

  logic [SIZE-1:0] step_rem;
  logic            step_qbit;
  logic [SIZE-1:0] shreg_next;
  logic [SIZE-1:0] res_q;
  logic [SIZE-1:0] res_r;
  logic [SIZE-1:0] a_mag;
  logic [SIZE-1:0] b_mag;

  divider_step #(
    .SIZE(SIZE)
  ) u_step (
    .rem     (rem_q),
    .bit_in  (shreg_q[SIZE-1]),
    .divisor (divisor_q),
    .rem_next(step_rem),
    .q_bit   (step_qbit)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom.
  assign shreg_next = {shreg_q[SIZE-2:0], step_qbit};

`ifdef DIVIDER_SIGNED_EN
  logic neg_q_q, neg_q_d;
  logic neg_r_q, neg_r_d;
  logic ovf_q, ovf_d;
  logic over_q, over_d;

  // Magnitudes; the most-negative value maps onto itself, which reads correctly unsigned.
  assign a_mag = a[SIZE-1] ? -a : a;
  assign b_mag = b[SIZE-1] ? -b : b;

  // Sign fix-up of the unsigned result: quotient truncates toward zero, remainder follows a.
  always_comb begin
    res_q = neg_q_q ? -shreg_next : shreg_next;
    res_r = neg_r_q ? -step_rem : step_rem;
  end

  // Sign and overflow bookkeeping captured at launch, applied at the result edge.
  always_comb begin
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    ovf_d   = ovf_q;
    over_d  = over_q;
    if (state_q == StIdle && start) begin
      over_d = 1'b0;
      if (b != '0) begin
        neg_q_d = a[SIZE-1] ^ b[SIZE-1];
        neg_r_d = a[SIZE-1];
        ovf_d   = (a == {1'b1, {(SIZE-1){1'b0}}}) && (b == '1);
      end
    end else if (state_q == StCalc && cnt_q == LastCnt) begin
      over_d = ovf_q;
    end
  end

  // Signed-mode state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      ovf_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      ovf_q   <= ovf_d;
      over_q  <= over_d;
    end
  end

  assign over = over_q;
`else
  assign a_mag = a;
  assign b_mag = b;

  // Unsigned mode: the core result is final.
  always_comb begin
    res_q = shreg_next;
    res_r = step_rem;
  end

  assign over = 1'b0;
`endif

  // Next-state and datapath updates; done defaults low so it only pulses.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    shreg_d    = shreg_q;
    divisor_d  = divisor_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    r_d        = r_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          div_zero_d = 1'b0;
          if (b == '0) begin
            // Divide by zero resolves on the accepting edge without entering CALC.
            q_d        = '1;
            r_d        = a;
            div_zero_d = 1'b1;
            done_d     = 1'b1;
            state_d    = StDone;
          end else begin
            divisor_d = b_mag;
            rem_d     = '0;
            shreg_d   = a_mag;
            cnt_d     = '0;
            busy_d    = 1'b1;
            state_d   = StCalc;
          end
        end
      end
      StCalc: begin
        rem_d   = step_rem;
        shreg_d = shreg_next;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          q_d     = res_q;
          r_d     = res_r;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q      <= '0;
      shreg_q    <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
      q_q        <= '0;
      r_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      rem_q      <= rem_d;
      shreg_q    <= shreg_d;
      divisor_q  <= divisor_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign q        = q_q;
  assign r        = r_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed vectors, reset abort, and randomized
// divides (with start/operand noise during CALC and DONE) against an arithmetic model.
module tb_divider_seq;

  localparam int unsigned S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [S-1:0] a;
  logic [S-1:0] b;
  logic         busy;
  logic         done;
  logic [S-1:0] q;
  logic [S-1:0] r;
  logic         div_zero;
  logic         over;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  divider_seq #(
    .SIZE(S)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .q       (q),
    .r       (r),
    .div_zero(div_zero),
    .over    (over)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected result straight from the arithmetic definition of division.
  task automatic model(input logic [S-1:0] av, input logic [S-1:0] bv,
                       output logic [S-1:0] eq, output logic [S-1:0] er,
                       output logic edz, output logic eov);
    int sa;
    int sb;
    int qi;
    int ri;
    edz = 1'b0;
    eov = 1'b0;
    eq  = '0;
    er  = '0;
    if (bv == '0) begin
      eq  = '1;
      er  = av;
      edz = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      sa = $signed(av);
      sb = $signed(bv);
      if (sa == -(2 ** (S - 1)) && sb == -1) begin
        eq  = av;
        er  = '0;
        eov = 1'b1;
      end else begin
        qi = sa / sb;
        ri = sa % sb;
        eq = qi[S-1:0];
        er = ri[S-1:0];
      end
`else
      sa = int'(av);
      sb = int'(bv);
      qi = sa / sb;
      ri = sa % sb;
      eq = qi[S-1:0];
      er = ri[S-1:0];
`endif
    end
  endtask

  // Launch one divide and check timing, result and the single-cycle done pulse.
  task automatic do_div(input logic [S-1:0] av, input logic [S-1:0] bv, input bit scramble);
    logic [S-1:0] eq;
    logic [S-1:0] er;
    logic         edz;
    logic         eov;
    int           extra;
    int           busy_cnt;
    int           exp_lat;
    model(av, bv, eq, er, edz, eov);
    exp_lat = (bv == '0) ? 0 : int'(S);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    extra    = 0;
    busy_cnt = 0;
    @(negedge clk);
    while (!done && extra < int'(S) + 4) begin
      if (busy) busy_cnt++;
      if (scramble) begin
        start = 1'($urandom_range(0, 1));
        a     = S'($urandom);
        b     = S'($urandom);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      extra++;
      @(negedge clk);
    end
    check("latency", 32'(extra), 32'(exp_lat));
    check("busy_cycles", 32'(busy_cnt), 32'(exp_lat));
    check("done", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("q", 32'(q), 32'(eq));
    check("r", 32'(r), 32'(er));
    check("div_zero", 32'(div_zero), 32'(edz));
    check("over", 32'(over), 32'(eov));
    // A start seen in DONE must not launch anything.
    if (scramble) begin
      start = 1'b1;
      a     = S'($urandom);
      b     = S'($urandom);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("q_hold", 32'(q), 32'(eq));
    check("r_hold", 32'(r), 32'(er));
    check("div_zero_hold", 32'(div_zero), 32'(edz));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_r", 32'(r), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    check("rst_over", 32'(over), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_div(4'b1111, 4'b0100, 1'b0);
    do_div(4'b1001, 4'b1111, 1'b0);
    do_div(4'b1111, 4'b0001, 1'b0);
    do_div(4'b0110, 4'b0000, 1'b0);
    do_div(4'b1111, 4'b0011, 1'b1);
    do_div(4'b1001, 4'b0010, 1'b0);
    do_div(4'b1000, 4'b1111, 1'b0);
    do_div(4'b0111, 4'b0011, 1'b0);

    // Reset in the middle of CALC aborts with no done pulse.
    @(negedge clk);
    a     = 4'b1111;
    b     = 4'b0100;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_q", 32'(q), 32'd0);
    check("abort_r", 32'(r), 32'd0);
    check("abort_div_zero", 32'(div_zero), 32'd0);
    check("abort_over", 32'(over), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    do_div(4'b1000, 4'b0011, 1'b0);

    for (int i = 0; i < 200; i++) begin
      logic [S-1:0] av;
      logic [S-1:0] bv;
      av = S'($urandom);
      bv = ($urandom_range(0, 7) == 0) ? '0 : S'($urandom);
      do_div(av, bv, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
